// File: rtl/iomem_pwm_pkg.sv
// Register map, control/status bit positions and bus helpers shared by the
// PWM peripheral RTL and the generated firmware header.
package iomem_pwm_pkg;

  // Word indices into the block, taken from iomem_addr[6:2]
  localparam int unsigned REG_CTRL   = 0;
  localparam int unsigned REG_PRESC  = 1;
  localparam int unsigned REG_PERIOD = 2;
  localparam int unsigned REG_STATUS = 3;
  localparam int unsigned REG_DUTY0  = 4;

  localparam int unsigned CTRL_EN     = 0;
  localparam int unsigned CTRL_IRQEN  = 1;
  localparam int unsigned CTRL_INV    = 8;
  localparam int unsigned STATUS_WRAP = 16;

  typedef enum logic [2:0] {
    SEL_CTRL,
    SEL_PRESC,
    SEL_PERIOD,
    SEL_STATUS,
    SEL_DUTY,
    SEL_NONE
  } reg_sel_e;

  function automatic logic [31:0] strobe_merge(input logic [31:0] cur,
                                               input logic [31:0] wdata,
                                               input logic [3:0]  wstrb);
    logic [31:0] res;
    res = cur;
    for (int unsigned b = 0; b < 4; b++) begin
      if (wstrb[b]) res[8*b +: 8] = wdata[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/iomem_pwm_channel.sv
// One PWM channel: active duty register loaded from the shadow on request,
// compare against the shared counter, polarity select, registered output.
module pwm_channel #(
  parameter int unsigned CW = 16
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          en,
  input  logic          load,
  input  logic          inv,
  input  logic [CW-1:0] cnt,
  input  logic [CW-1:0] duty,
  output logic          pwm
);

  logic [CW-1:0] active_duty;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      active_duty <= '0;
      pwm         <= 1'b0;
    end else begin
      if (load) active_duty <= duty;
      pwm <= en ? ((cnt < active_duty) ^ inv) : inv;
    end
  end

endmodule

// File: rtl/iomem_pwm.sv
// Multi-channel PWM peripheral on the picosoc iomem bus: register decode,
// prescaler and shared period counter; per-channel compare in pwm_channel.
module iomem_pwm
  import iomem_pwm_pkg::*;
#(
  parameter int unsigned NCH  = 2,
  parameter int unsigned CW   = 16,
  parameter logic [7:0]  BASE = 8'h03
) (
  input  logic           clk,
  input  logic           resetn,
  input  logic           iomem_valid,
  output logic           iomem_ready,
  input  logic [3:0]     iomem_wstrb,
  input  logic [31:0]    iomem_addr,
  input  logic [31:0]    iomem_wdata,
  output logic [31:0]    iomem_rdata,
  output logic [NCH-1:0] pwm_out,
  output logic           irq
);

  logic           en;
  logic           irqen;
  logic [NCH-1:0] inv;
  logic [CW-1:0]  presc;
  logic [CW-1:0]  period;
  logic [CW-1:0]  pcnt;
  logic [CW-1:0]  cnt;
  logic           wrap;
  logic [CW-1:0]  duty [NCH];

  logic           access;
  logic           wr;
  logic [4:0]     idx;
  reg_sel_e       sel;
  logic [31:0]    rd_word;
  logic [31:0]    wr_word;
  logic           tick;
  logic           wrap_evt;
  logic           duty_load;
  logic           wrap_clr;
  logic           unused;

  assign access = iomem_valid && !iomem_ready && (iomem_addr[31:24] == BASE);
  assign wr     = access && (|iomem_wstrb);
  assign idx    = iomem_addr[6:2];

  always_comb begin
    if (32'(idx) == REG_CTRL)        sel = SEL_CTRL;
    else if (32'(idx) == REG_PRESC)  sel = SEL_PRESC;
    else if (32'(idx) == REG_PERIOD) sel = SEL_PERIOD;
    else if (32'(idx) == REG_STATUS) sel = SEL_STATUS;
    else if (32'(idx) >= REG_DUTY0 && 32'(idx) < REG_DUTY0 + NCH) sel = SEL_DUTY;
    else                             sel = SEL_NONE;
  end

  always_comb begin
    rd_word = '0;
    case (sel)
      SEL_CTRL: begin
        rd_word[CTRL_EN]         = en;
        rd_word[CTRL_IRQEN]      = irqen;
        rd_word[CTRL_INV +: NCH] = inv;
      end
      SEL_PRESC:  rd_word[CW-1:0] = presc;
      SEL_PERIOD: rd_word[CW-1:0] = period;
      SEL_STATUS: begin
        rd_word[CW-1:0]    = cnt;
        rd_word[STATUS_WRAP] = wrap;
      end
      SEL_DUTY: begin
        for (int unsigned i = 0; i < NCH; i++) begin
          if (32'(idx) == REG_DUTY0 + i) rd_word[CW-1:0] = duty[i];
        end
      end
      default: rd_word = '0;
    endcase
  end

  // Merging strobed bytes into the current readback keeps unwritten bytes and
  // drops bits beyond each field once truncated.
  assign wr_word = strobe_merge(rd_word, iomem_wdata, iomem_wstrb);

  assign tick      = en && (pcnt == presc);
  assign wrap_evt  = tick && (cnt >= period);
  assign duty_load = !en || wrap_evt;
  assign wrap_clr  = wr && (sel == SEL_STATUS) && iomem_wstrb[STATUS_WRAP/8]
                     && iomem_wdata[STATUS_WRAP];
  assign irq       = wrap && irqen;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      en          <= 1'b0;
      irqen       <= 1'b0;
      inv         <= '0;
      presc       <= '0;
      period      <= '0;
      pcnt        <= '0;
      cnt         <= '0;
      wrap        <= 1'b0;
      iomem_ready <= 1'b0;
      iomem_rdata <= '0;
      for (int unsigned i = 0; i < NCH; i++) duty[i] <= '0;
    end else begin
      iomem_ready <= access;
      if (access) iomem_rdata <= rd_word;

      if (!en) begin
        pcnt <= '0;
        cnt  <= '0;
      end else if (tick) begin
        pcnt <= '0;
        cnt  <= wrap_evt ? '0 : cnt + 1'b1;
      end else begin
        pcnt <= pcnt + 1'b1;
      end

      if (wr) begin
        case (sel)
          SEL_CTRL: begin
            en    <= wr_word[CTRL_EN];
            irqen <= wr_word[CTRL_IRQEN];
            inv   <= wr_word[CTRL_INV +: NCH];
          end
          SEL_PRESC:  presc  <= wr_word[CW-1:0];
          SEL_PERIOD: period <= wr_word[CW-1:0];
          SEL_DUTY: begin
            for (int unsigned i = 0; i < NCH; i++) begin
              if (32'(idx) == REG_DUTY0 + i) duty[i] <= wr_word[CW-1:0];
            end
          end
          default: ;
        endcase
      end

      // A wrap in the same cycle as a write-1-clear leaves the flag set
      if (wrap_evt)      wrap <= 1'b1;
      else if (wrap_clr) wrap <= 1'b0;
    end
  end

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    pwm_channel #(.CW(CW)) u_ch (
      .clk    (clk),
      .resetn (resetn),
      .en     (en),
      .load   (duty_load),
      .inv    (inv[g]),
      .cnt    (cnt),
      .duty   (duty[g]),
      .pwm    (pwm_out[g])
    );
  end

  assign unused = ^{iomem_addr[23:7], iomem_addr[1:0], wr_word[31:CW]};

endmodule

// File: tb/tb_iomem_pwm.sv
// Bench for iomem_pwm: bus register checks plus randomized PWM runs compared
// against a closed-form timing model (period, duty schedule, wrap flag).
module tb_iomem_pwm;

  localparam int NCH = 2;
  localparam int CW  = 16;

  logic           clk = 1'b0;
  logic           resetn = 1'b0;
  logic           iomem_valid = 1'b0;
  logic           iomem_ready;
  logic [3:0]     iomem_wstrb = '0;
  logic [31:0]    iomem_addr = '0;
  logic [31:0]    iomem_wdata = '0;
  logic [31:0]    iomem_rdata;
  logic [NCH-1:0] pwm_out;
  logic           irq;

  iomem_pwm #(.NCH(NCH), .CW(CW), .BASE(8'h03)) dut (
    .clk         (clk),
    .resetn      (resetn),
    .iomem_valid (iomem_valid),
    .iomem_ready (iomem_ready),
    .iomem_wstrb (iomem_wstrb),
    .iomem_addr  (iomem_addr),
    .iomem_wdata (iomem_wdata),
    .iomem_rdata (iomem_rdata),
    .pwm_out     (pwm_out),
    .irq         (irq)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference model: one enable edge e0, fixed PRESC/PERIOD, a log of duty
  // writes and status clears stamped with the clock edge they land on.
  typedef struct {int ch; int e; int v;} duty_wr_t;
  duty_wr_t duty_log[$];
  int       clear_log[$];
  int       e0, P, N, L;
  logic           irqen_m;
  logic [NCH-1:0] inv_m;
  bit             running = 0;

  function automatic int duty_at(input int ch, input int wrap_edge);
    int d = 0;
    foreach (duty_log[k]) if (duty_log[k].ch == ch && duty_log[k].e < wrap_edge) d = duty_log[k].v;
    return d;
  endfunction

  function automatic bit wrap_at(input int c);
    int j, w, lc;
    j = c - e0;
    lc = -1;
    if (j < L) return 1'b0;
    w = e0 + (j / L) * L;
    foreach (clear_log[k]) if (clear_log[k] <= c) lc = clear_log[k];
    return w >= lc;
  endfunction

  always @(negedge clk) begin
    int j, jj, k, cnt_m;
    bit exp;
    if (running && resetn) begin
      j = cyc - e0;
      if (j >= 1) begin
        jj    = j - 1;
        k     = jj / L;
        cnt_m = (jj / (P + 1)) % (N + 1);
        for (int ch = 0; ch < NCH; ch++) begin
          exp = (cnt_m < duty_at(ch, e0 + k * L)) ^ inv_m[ch];
          check($sformatf("pwm%0d", ch), 32'(pwm_out[ch]), 32'(exp));
        end
        check("irq", 32'(irq), 32'(irqen_m & wrap_at(cyc)));
      end
    end
  end

  // Called at a negedge; the request lands on the next posedge (returned as re).
  task automatic bus(input logic [31:0] a, input logic [3:0] ws, input logic [31:0] wd,
                     output logic [31:0] rd, output int re);
    iomem_valid = 1'b1;
    iomem_addr  = a;
    iomem_wstrb = ws;
    iomem_wdata = wd;
    re = cyc + 1;
    @(negedge clk);
    check("ready", 32'(iomem_ready), 32'd1);
    rd = iomem_rdata;
    iomem_valid = 1'b0;
    iomem_wstrb = '0;
    @(negedge clk);
    check("ready_pulse", 32'(iomem_ready), 32'd0);
  endtask

  task automatic wr(input int off, input logic [31:0] d, output int e);
    logic [31:0] dummy;
    bus(32'h0300_0000 + off, 4'hF, d, dummy, e);
  endtask

  task automatic rd(input int off, output logic [31:0] d);
    int e;
    bus(32'h0300_0000 + off, 4'h0, 32'h0, d, e);
  endtask

  task automatic wait_edge(input int t);
    while (cyc < t - 1) @(negedge clk);
  endtask

  task automatic do_duty(input int ch, input int v);
    int e;
    duty_log.push_back('{ch, cyc + 1, v});
    wr(16 + 4 * ch, v, e);
  endtask

  task automatic do_clear();
    int e;
    clear_log.push_back(cyc + 1);
    wr(12, 32'h0001_0000, e);
  endtask

  task automatic do_status_read();
    logic [31:0] d;
    int r;
    r = cyc + 1;
    rd(12, d);
    check("status", d, 32'((((r - 1 - e0) / (P + 1)) % (N + 1))) | (32'(wrap_at(r - 1)) << 16));
  endtask

  task automatic check_all_zero(input string tag);
    logic [31:0] d;
    for (int off = 0; off < 16 + 4 * NCH; off += 4) begin
      rd(off, d);
      check($sformatf("%s_reg%0h", tag, off), d, 32'h0);
    end
  endtask

  initial begin
    logic [31:0] d;
    int e, t, n, ev;

    repeat (3) @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    check("rst_pwm", 32'(pwm_out), 32'h0);
    check("rst_irq", 32'(irq), 32'h0);
    check("rst_ready", 32'(iomem_ready), 32'h0);
    check("rst_rdata", iomem_rdata, 32'h0);
    check_all_zero("rst");

    // Bus decode, byte strobes and field widths
    wr(8, 32'h0000_1234, e);
    rd(8, d);
    check("period_rd", d, 32'h1234);
    bus(32'h0300_0008, 4'b0001, 32'h0000_ABCD, d, e);
    rd(8, d);
    check("period_strb", d, 32'h12CD);
    wr(4, 32'hFFFF_FFFF, e);
    rd(4, d);
    check("presc_width", d, 32'hFFFF);
    wr(4, 32'h0, e);
    wr(0, 32'hFFFF_FFFE, e);
    rd(0, d);
    check("ctrl_fields", d, 32'h0302);
    check("inv_idle", 32'(pwm_out), 32'h3);
    wr(0, 32'h0, e);
    @(negedge clk);
    check("idle_pwm0", 32'(pwm_out), 32'h0);
    wr(32'h40, 32'hFFFF_FFFF, e);
    rd(32'h40, d);
    check("unmapped_rd", d, 32'h0);
    iomem_valid = 1'b1;
    iomem_addr  = 32'h0200_0000;
    iomem_wstrb = 4'hF;
    iomem_wdata = 32'hFFFF_FFFF;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("no_decode_ready", 32'(iomem_ready), 32'h0);
    end
    iomem_valid = 1'b0;
    iomem_wstrb = '0;
    @(negedge clk);

    // PWM runs: segment 0 is the directed basic/shadow/irq scenario
    for (int seg = 0; seg < 7; seg++) begin
      duty_log.delete();
      clear_log.delete();
      if (seg == 0) begin
        P = 0; N = 9; irqen_m = 1'b1; inv_m = '0;
      end else begin
        P = $urandom_range(0, 2);
        N = $urandom_range(1, 8);
        irqen_m = 1'($urandom_range(0, 1));
        inv_m = NCH'($urandom_range(0, (1 << NCH) - 1));
      end
      L = (P + 1) * (N + 1);
      wr(4, P, e);
      wr(8, N, e);
      for (int ch = 0; ch < NCH; ch++) begin
        if (seg == 0) do_duty(ch, (ch == 0) ? 3 : 10);
        else          do_duty(ch, $urandom_range(0, N + 2));
      end
      do_clear();
      wr(0, (32'(inv_m) << 8) | (32'(irqen_m) << 1) | 32'h1, e);
      e0 = e;
      running = 1;

      if (seg == 0) begin
        wait_edge(e0 + L);          do_duty(0, 7);
        wait_edge(e0 + L + 4);      do_clear();
        wait_edge(e0 + 2 * L);      do_clear();
        wait_edge(e0 + 2 * L + 5);  do_duty(0, 3);
        wait_edge(e0 + 3 * L + 2);  do_status_read();
      end

      n = 0;
      while (cyc < e0 + 6 * L && n < 40) begin
        t = cyc + 1 + $urandom_range(0, L);
        if ($urandom_range(0, 2) == 0) t = e0 + ((cyc + 1 - e0 + L - 1) / L) * L;
        wait_edge(t);
        ev = $urandom_range(0, 2);
        case (ev)
          0:       do_duty($urandom_range(0, NCH - 1), $urandom_range(0, N + 2));
          1:       do_clear();
          default: do_status_read();
        endcase
        n++;
      end
      wait_edge(e0 + 7 * L);
      running = 0;

      wr(0, 32'(inv_m) << 8, e);
      check("disable_inv", 32'(pwm_out), 32'(inv_m));
      rd(12, d);
      check("disable_cnt", d & 32'hFFFF, 32'h0);
      wr(0, 32'h0, e);
      check("disable_zero", 32'(pwm_out), 32'h0);
    end

    // Reset in the middle of a run and of a bus access
    wr(0, 32'h0000_0303, e);
    repeat (13) @(negedge clk);
    iomem_valid = 1'b1;
    iomem_addr  = 32'h0300_0000;
    iomem_wstrb = 4'h0;
    resetn = 1'b0;
    @(negedge clk);
    check("midrst_ready", 32'(iomem_ready), 32'h0);
    check("midrst_pwm", 32'(pwm_out), 32'h0);
    check("midrst_irq", 32'(irq), 32'h0);
    check("midrst_rdata", iomem_rdata, 32'h0);
    iomem_valid = 1'b0;
    resetn = 1'b1;
    @(negedge clk);
    check_all_zero("midrst");
    check("midrst_pwm_after", 32'(pwm_out), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout got %0d expected finish", cyc);
    $fatal(1);
  end

endmodule
